// File: rtl/ysyx_24100012_load_unit_if.sv
// rtl/ysyx_24100012_load_unit_if.sv - request, memory read channel and response bundle of the load unit
// slave is the load unit's view; master is the execute/memory/writeback side.
interface ysyx_24100012_load_unit_if #(
  parameter int XLEN       = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int TAG_WIDTH  = 5
);
  logic                  req_valid;
  logic                  req_ready;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [2:0]            req_func3;
  logic [TAG_WIDTH-1:0]  req_tag;

  logic                  mem_arvalid;
  logic                  mem_arready;
  logic [ADDR_WIDTH-1:0] mem_araddr;
  logic [2:0]            mem_arsize;
  logic                  mem_rvalid;
  logic                  mem_rready;
  logic [XLEN-1:0]       mem_rdata;
  logic [1:0]            mem_rresp;

  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [XLEN-1:0]       rsp_data;
  logic [TAG_WIDTH-1:0]  rsp_tag;
  logic                  rsp_err;

  modport slave (
    input  req_valid, req_addr, req_func3, req_tag,
    input  mem_arready, mem_rvalid, mem_rdata, mem_rresp,
    input  rsp_ready,
    output req_ready,
    output mem_arvalid, mem_araddr, mem_arsize, mem_rready,
    output rsp_valid, rsp_data, rsp_tag, rsp_err
  );

  modport master (
    output req_valid, req_addr, req_func3, req_tag,
    output mem_arready, mem_rvalid, mem_rdata, mem_rresp,
    output rsp_ready,
    input  req_ready,
    input  mem_arvalid, mem_araddr, mem_arsize, mem_rready,
    input  rsp_valid, rsp_data, rsp_tag, rsp_err
  );
endinterface

// File: rtl/ysyx_24100012_load_unit.sv
// rtl/ysyx_24100012_load_unit.sv - single-outstanding RV32/RV64 load unit
// Aligned bus read, lane shift and sign/zero extension, result held until writeback takes it.
module ysyx_24100012_load_unit #(
  parameter int XLEN       = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int TAG_WIDTH  = 5
) (
  input  logic                          clk,
  input  logic                          rst,
  ysyx_24100012_load_unit_if.slave      bus
);
  localparam int OFFW = $clog2(XLEN / 8);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

  state_t                state;
  state_t                state_nx;

  logic [2:0]            func3_q;
  logic [OFFW-1:0]       off_q;
  logic [ADDR_WIDTH-1:0] araddr_q;
  logic [2:0]            arsize_q;
  logic [XLEN-1:0]       rsp_data_q;
  logic [TAG_WIDTH-1:0]  rsp_tag_q;
  logic                  rsp_err_q;

  logic                  illegal;
  logic                  misaligned;
  logic                  req_bad;
  logic                  accept;
  logic [XLEN-1:0]       shifted;
  logic [XLEN-1:0]       load_ext;

  assign accept = (state == IDLE) && bus.req_valid;

  always_comb begin
    illegal    = 1'b0;
    misaligned = 1'b0;
    if (bus.req_func3 == 3'b111)
      illegal = 1'b1;
    if ((XLEN == 32) && ((bus.req_func3 == 3'b011) || (bus.req_func3 == 3'b110)))
      illegal = 1'b1;
    case (bus.req_func3[1:0])
      2'b01:   misaligned = bus.req_addr[0];
      2'b10:   misaligned = |bus.req_addr[1:0];
      2'b11:   misaligned = |bus.req_addr[2:0];
      default: misaligned = 1'b0;
    endcase
    req_bad = illegal || misaligned;
  end

  // The bus returns the whole aligned word; bring the addressed bytes down to lane 0.
  always_comb begin
    shifted  = bus.mem_rdata >> {off_q, 3'b000};
    load_ext = '0;
    case (func3_q)
      3'b000:  load_ext = XLEN'($signed(shifted[7:0]));
      3'b001:  load_ext = XLEN'($signed(shifted[15:0]));
      3'b010:  load_ext = XLEN'($signed(shifted[31:0]));
      3'b011:  load_ext = shifted;
      3'b100:  load_ext = XLEN'(shifted[7:0]);
      3'b101:  load_ext = XLEN'(shifted[15:0]);
      3'b110:  load_ext = XLEN'(shifted[31:0]);
      default: load_ext = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (accept)          state_nx = req_bad ? RESP : ADDR;
      ADDR: if (bus.mem_arready) state_nx = DATA;
      DATA: if (bus.mem_rvalid)  state_nx = RESP;
      RESP: if (bus.rsp_ready)   state_nx = IDLE;
      default:                   state_nx = IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready   = (state == IDLE);
    bus.mem_arvalid = (state == ADDR);
    bus.mem_rready  = (state == DATA);
    bus.rsp_valid   = (state == RESP);
    bus.mem_araddr  = araddr_q;
    bus.mem_arsize  = arsize_q;
    bus.rsp_data    = rsp_data_q;
    bus.rsp_tag     = rsp_tag_q;
    bus.rsp_err     = rsp_err_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      func3_q    <= '0;
      off_q      <= '0;
      araddr_q   <= '0;
      arsize_q   <= '0;
      rsp_data_q <= '0;
      rsp_tag_q  <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      if (accept) begin
        func3_q    <= bus.req_func3;
        off_q      <= bus.req_addr[OFFW-1:0];
        araddr_q   <= {bus.req_addr[ADDR_WIDTH-1:OFFW], {OFFW{1'b0}}};
        arsize_q   <= {1'b0, bus.req_func3[1:0]};
        rsp_tag_q  <= bus.req_tag;
        rsp_err_q  <= req_bad;
        rsp_data_q <= '0;
      end
      if ((state == DATA) && bus.mem_rvalid) begin
        rsp_err_q  <= |bus.mem_rresp;
        rsp_data_q <= (|bus.mem_rresp) ? '0 : load_ext;
      end
    end
  end
endmodule

// File: tb/tb_ysyx_24100012_load_unit.sv
// tb/tb_ysyx_24100012_load_unit.sv - directed bench for the load unit at XLEN=32 and XLEN=64
module tb_ysyx_24100012_load_unit;
  logic        clk = 1'b0;
  logic        rst;
  logic        sel64;
  logic        req_valid;
  logic [31:0] req_addr;
  logic [2:0]  req_func3;
  logic [4:0]  req_tag;
  logic        mem_arready;
  logic        mem_rvalid;
  logic [63:0] rdata;
  logic [1:0]  rresp;
  logic        rsp_ready;
  logic [63:0] mem_word;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ysyx_24100012_load_unit_if #(.XLEN(32), .ADDR_WIDTH(32), .TAG_WIDTH(5)) if32 ();
  ysyx_24100012_load_unit_if #(.XLEN(64), .ADDR_WIDTH(32), .TAG_WIDTH(5)) if64 ();

  ysyx_24100012_load_unit #(.XLEN(32), .ADDR_WIDTH(32), .TAG_WIDTH(5)) u32 (
    .clk (clk),
    .rst (rst),
    .bus (if32)
  );
  ysyx_24100012_load_unit #(.XLEN(64), .ADDR_WIDTH(32), .TAG_WIDTH(5)) u64 (
    .clk (clk),
    .rst (rst),
    .bus (if64)
  );

  assign if32.req_valid   = req_valid & ~sel64;
  assign if64.req_valid   = req_valid & sel64;
  assign if32.req_addr    = req_addr;
  assign if64.req_addr    = req_addr;
  assign if32.req_func3   = req_func3;
  assign if64.req_func3   = req_func3;
  assign if32.req_tag     = req_tag;
  assign if64.req_tag     = req_tag;
  assign if32.mem_arready = mem_arready;
  assign if64.mem_arready = mem_arready;
  assign if32.mem_rvalid  = mem_rvalid;
  assign if64.mem_rvalid  = mem_rvalid;
  assign if32.mem_rdata   = rdata[31:0];
  assign if64.mem_rdata   = rdata;
  assign if32.mem_rresp   = rresp;
  assign if64.mem_rresp   = rresp;
  assign if32.rsp_ready   = rsp_ready;
  assign if64.rsp_ready   = rsp_ready;

  wire        o_req_ready = sel64 ? if64.req_ready   : if32.req_ready;
  wire        o_arvalid   = sel64 ? if64.mem_arvalid : if32.mem_arvalid;
  wire [31:0] o_araddr    = sel64 ? if64.mem_araddr  : if32.mem_araddr;
  wire [2:0]  o_arsize    = sel64 ? if64.mem_arsize  : if32.mem_arsize;
  wire        o_rready    = sel64 ? if64.mem_rready  : if32.mem_rready;
  wire        o_rsp_valid = sel64 ? if64.rsp_valid   : if32.rsp_valid;
  wire [63:0] o_rsp_data  = sel64 ? if64.rsp_data    : {32'b0, if32.rsp_data};
  wire [4:0]  o_rsp_tag   = sel64 ? if64.rsp_tag     : if32.rsp_tag;
  wire        o_rsp_err   = sel64 ? if64.rsp_err     : if32.rsp_err;

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", name, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, " req_ready"}, 64'(o_req_ready), 64'd1);
    check({pfx, " arvalid"},   64'(o_arvalid),   64'd0);
    check({pfx, " rready"},    64'(o_rready),    64'd0);
    check({pfx, " rsp_valid"}, 64'(o_rsp_valid), 64'd0);
    check({pfx, " rsp_err"},   64'(o_rsp_err),   64'd0);
    check({pfx, " araddr"},    64'(o_araddr),    64'd0);
    check({pfx, " arsize"},    64'(o_arsize),    64'd0);
    check({pfx, " rsp_data"},  o_rsp_data,       64'd0);
    check({pfx, " rsp_tag"},   64'(o_rsp_tag),   64'd0);
  endtask

  // Starts and ends at a falling edge; the falling edge after the accept edge is cycle 1.
  task automatic run_load(input string nm, input logic [31:0] a, input logic [2:0] f,
                          input logic [4:0] t, input bit use_bus, input int arw, input int rw,
                          input logic [1:0] rr, input logic [31:0] exp_aa, input logic [2:0] exp_as,
                          input logic [63:0] exp_d, input bit exp_e, input int rspw, input bit abort);
    check({nm, " req_ready idle"}, 64'(o_req_ready), 64'd1);
    req_valid = 1'b1; req_addr = a; req_func3 = f; req_tag = t;
    @(posedge clk); @(negedge clk);
    req_valid = 1'b0; req_addr = 32'hDEADBEEF; req_func3 = 3'b111; req_tag = 5'h1F;
    check({nm, " req_ready busy"}, 64'(o_req_ready), 64'd0);
    if (use_bus) begin
      check({nm, " arvalid c1"}, 64'(o_arvalid), 64'd1);
      check({nm, " araddr"}, 64'(o_araddr), 64'(exp_aa));
      check({nm, " arsize"}, 64'(o_arsize), 64'(exp_as));
      check({nm, " rready in ADDR"}, 64'(o_rready), 64'd0);
      for (int i = 0; i < arw; i++) begin
        mem_arready = 1'b0; mem_rvalid = 1'b1; rdata = ~mem_word; rresp = 2'd0;
        @(posedge clk); @(negedge clk);
        check({nm, " arvalid held"}, 64'(o_arvalid), 64'd1);
        check({nm, " araddr held"}, 64'(o_araddr), 64'(exp_aa));
        check({nm, " arsize held"}, 64'(o_arsize), 64'(exp_as));
      end
      mem_arready = 1'b1; mem_rvalid = 1'b0;
      @(posedge clk); @(negedge clk);
      mem_arready = 1'b0;
      check({nm, " arvalid drop"}, 64'(o_arvalid), 64'd0);
      check({nm, " rready"}, 64'(o_rready), 64'd1);
      if (abort) begin
        rst = 1'b1;
        #1;
        check_reset_outputs({nm, " async rst"});
        rst = 1'b0;
        @(negedge clk);
        return;
      end
      for (int i = 0; i < rw; i++) begin
        mem_rvalid = 1'b0;
        @(posedge clk); @(negedge clk);
        check({nm, " rready held"}, 64'(o_rready), 64'd1);
        check({nm, " rsp_valid early"}, 64'(o_rsp_valid), 64'd0);
      end
      mem_rvalid = 1'b1; rdata = mem_word; rresp = rr;
      @(posedge clk); @(negedge clk);
      mem_rvalid = 1'b0; rdata = ~mem_word; rresp = 2'd0;
      check({nm, " rready drop"}, 64'(o_rready), 64'd0);
    end else begin
      check({nm, " no bus"}, 64'(o_arvalid), 64'd0);
    end
    check({nm, " rsp_valid"}, 64'(o_rsp_valid), 64'd1);
    check({nm, " rsp_data"}, o_rsp_data, exp_d);
    check({nm, " rsp_err"}, 64'(o_rsp_err), 64'(exp_e));
    check({nm, " rsp_tag"}, 64'(o_rsp_tag), 64'(t));
    for (int i = 0; i < rspw; i++) begin
      rsp_ready = 1'b0;
      @(posedge clk); @(negedge clk);
      check({nm, " rsp_valid held"}, 64'(o_rsp_valid), 64'd1);
      check({nm, " rsp_data held"}, o_rsp_data, exp_d);
      check({nm, " rsp_tag held"}, 64'(o_rsp_tag), 64'(t));
      check({nm, " req_ready in RESP"}, 64'(o_req_ready), 64'd0);
      check({nm, " arvalid in RESP"}, 64'(o_arvalid), 64'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    rsp_ready = 1'b0;
    check({nm, " rsp_valid drop"}, 64'(o_rsp_valid), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; sel64 = 1'b0; req_valid = 1'b0; req_addr = '0; req_func3 = '0; req_tag = '0;
    mem_arready = 1'b0; mem_rvalid = 1'b0; rdata = '0; rresp = '0; rsp_ready = 1'b0;
    mem_word = 64'h00000000F1E2D3C4;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("rst32");
    sel64 = 1'b1;
    check_reset_outputs("rst64");
    sel64 = 1'b0;
    rst = 1'b0;
    @(negedge clk);

    run_load("LB",  32'h80000103, 3'b000, 5'd1, 1, 0, 0, 2'd0, 32'h80000100, 3'd0, 64'hFFFFFFF1, 0, 0, 0);
    run_load("LBU", 32'h80000102, 3'b100, 5'd2, 1, 0, 0, 2'd0, 32'h80000100, 3'd0, 64'h000000E2, 0, 0, 0);
    run_load("LH",  32'h80000102, 3'b001, 5'd3, 1, 0, 0, 2'd0, 32'h80000100, 3'd1, 64'hFFFFF1E2, 0, 0, 0);
    run_load("LHU", 32'h80000100, 3'b101, 5'd4, 1, 0, 0, 2'd0, 32'h80000100, 3'd1, 64'h0000D3C4, 0, 0, 0);
    run_load("LW",  32'h80000100, 3'b010, 5'd5, 1, 0, 0, 2'd0, 32'h80000100, 3'd2, 64'hF1E2D3C4, 0, 0, 0);
    run_load("LH misaligned", 32'h80000101, 3'b001, 5'd7, 0, 0, 0, 2'd0, 32'h0, 3'd0, 64'h0, 1, 0, 0);
    run_load("LD on RV32",    32'h80000100, 3'b011, 5'd7, 0, 0, 0, 2'd0, 32'h0, 3'd0, 64'h0, 1, 0, 0);
    run_load("f3 111",        32'h80000100, 3'b111, 5'd8, 0, 0, 0, 2'd0, 32'h0, 3'd0, 64'h0, 1, 0, 0);
    run_load("bus err",       32'h80000201, 3'b000, 5'd6, 1, 3, 0, 2'd2, 32'h80000200, 3'd0, 64'h0, 1, 0, 0);
    run_load("backpressure",  32'h80000104, 3'b010, 5'd9, 1, 0, 2, 2'd0, 32'h80000104, 3'd2, 64'hF1E2D3C4, 0, 5, 0);
    run_load("after bp",      32'h80000101, 3'b100, 5'd10, 1, 0, 0, 2'd0, 32'h80000100, 3'd0, 64'h000000D3, 0, 0, 0);

    sel64 = 1'b1;
    mem_word = 64'h8000000112345678;
    run_load("LWU64", 32'h00001004, 3'b110, 5'd11, 1, 0, 0, 2'd0, 32'h00001000, 3'd2, 64'h0000000080000001, 0, 0, 0);
    run_load("LW64",  32'h00001004, 3'b010, 5'd12, 1, 0, 0, 2'd0, 32'h00001000, 3'd2, 64'hFFFFFFFF80000001, 0, 0, 0);
    run_load("LD64",  32'h00002000, 3'b011, 5'd13, 1, 0, 0, 2'd0, 32'h00002000, 3'd3, 64'h8000000112345678, 0, 0, 0);
    run_load("LHU64", 32'h00001006, 3'b101, 5'd14, 1, 0, 1, 2'd0, 32'h00001000, 3'd1, 64'h0000000000008000, 0, 0, 0);
    run_load("LD64 misaligned", 32'h00002004, 3'b011, 5'd15, 0, 0, 0, 2'd0, 32'h0, 3'd0, 64'h0, 1, 0, 0);
    run_load("LD64 abort", 32'h00003000, 3'b011, 5'd16, 1, 1, 2, 2'd0, 32'h00003000, 3'd3, 64'h0, 0, 0, 1);
    run_load("LD64 post rst", 32'h00003008, 3'b011, 5'd17, 1, 0, 0, 2'd0, 32'h00003008, 3'd3, 64'h8000000112345678, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
